ram_word_display: RTL



---
 rtl/ram_word_display.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ram_word_display.sv
// Converts a 32-bit unsigned word to decimal with a sequential double-dabble engine
// and drives an 8-digit multiplexed, active-low seven-segment display.
module ram_word_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        busy,
    output logic        overflow
);

    localparam int DIV_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_shift;
    logic               w_done;

    logic [31:0]        r_last;
    logic [71:0]        r_sh;
    logic [5:0]         r_cnt;
    logic [39:0]        r_disp;
    logic               r_ovf;

    logic [DIV_W-1:0]   r_div;
    logic [2:0]         r_idx;
    logic               w_div_tc;
    logic [2:0]         w_idx_next;

    // One double-dabble step: correct every BCD nibble >= 5, then shift left.
    function automatic logic [71:0] dabble_step(input logic [71:0] sh);
        logic [71:0] t;
        t = sh;
        for (int k = 0; k < 10; k++) begin
            if (t[32 + 4*k +: 4] >= 4'd5)
                t[32 + 4*k +: 4] = t[32 + 4*k +: 4] + 4'd3;
        end
        return {t[70:0], 1'b0};
    endfunction

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] render(input logic [2:0] idx, input logic [39:0] disp,
                                          input logic ovf);
        logic       upper_nz;
        logic [3:0] dig;
        int         ii;
        ii       = int'(idx);
        upper_nz = 1'b0;
        dig      = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (k >= ii && disp[4*k +: 4] != 4'd0)
                upper_nz = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            if (k == ii)
                dig = disp[4*k +: 4];
        end
        if (ovf)
            return 7'h3F;
        if (ii != 0 && !upper_nz)
            return 7'h7F;
        return decode_digit(dig);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (value != r_last) w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == 6'd31)  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load  = (r_state == S_IDLE) && (value != r_last);
        w_shift = (r_state == S_SHIFT);
        w_done  = (r_state == S_DONE);
        busy    = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 32'd0;
            r_cnt  <= 6'd0;
            r_disp <= 40'd0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_load) begin
                r_last <= value;
                r_cnt  <= 6'd0;
            end else if (w_shift) begin
                r_cnt  <= r_cnt + 6'd1;
            end
            if (w_done) begin
                r_disp <= r_sh[71:32];
                r_ovf  <= |r_sh[71:64];
            end
        end
    end

    // The shift register is pure data; every conversion reloads it before use.
    always_ff @(posedge clk) begin
        if (w_load)
            r_sh <= {40'd0, value};
        else if (w_shift)
            r_sh <= dabble_step(r_sh);
    end

    always_comb begin
        w_div_tc   = (r_div == DIV_W'(REFRESH_DIV - 1));
        w_idx_next = w_div_tc ? r_idx + 3'd1 : r_idx;
    end

    // an/seg follow the next idx so the digit select and its pattern change together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_idx <= 3'd0;
            an    <= 8'hFE;
            seg   <= 7'h40;
        end else begin
            r_div <= w_div_tc ? '0 : r_div + DIV_W'(1);
            r_idx <= w_idx_next;
            an    <= ~(8'b1 << w_idx_next);
            seg   <= render(w_idx_next, r_disp, r_ovf);
        end
    end

    assign dp       = 1'b1;
    assign overflow = r_ovf;

endmodule
